// File: rtl/simd_div_core.sv
// -----------------------------------------------------------------------------
// simd_div_core
//   Iterative unsigned SIMD restoring divider. It sits behind the AXI4-Lite
//   register slave of my_simd_divider. Lanes are 4x8, 2x16 or 1x32. Every lane
//   produces one quotient bit per clock, and all lanes run in parallel.
//
// Ports
//   s00_axi_aclk     clock
//   s00_axi_aresetn  asynchronous active-low reset
//   start            single-cycle request, sampled only while idle
//   mode             00=4x8, 01=2x16, 10=1x32, 11=illegal
//   dividend         packed lanes, lane i at bits [i*W+W-1:i*W]
//   divisor          packed lanes, same layout
//   busy             high while the iteration runs
//   done             one-cycle pulse when results become valid
//   result_valid     high from done until the next accepted start
//   quotient         packed lane quotients
//   remainder        packed lane remainders
//   dz_flags         bit i = lane i divisor was zero (unused lanes read 0)
//   mode_err         set when a start was accepted with mode 11
// -----------------------------------------------------------------------------
module simd_div_core #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [1:0]  MODE_RESET = 2'b10
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic [3:0]        dz_flags,
  output logic              mode_err
);

  localparam logic [1:0] MODE_4X8     = 2'b00;
  localparam logic [1:0] MODE_2X16    = 2'b01;
  localparam logic [1:0] MODE_1X32    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic [3:0]        dzFlags_q, dzFlags_d;
  logic              modeErr_q, modeErr_d;
  logic              resultValid_q, resultValid_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] stepRem, stepQuo, stepDvd;
  logic [3:0]        dzLanes;

  function automatic logic [5:0] laneWidth(input logic [1:0] m);
    case (m)
      MODE_4X8:  laneWidth = 6'd8;
      MODE_2X16: laneWidth = 6'd16;
      default:   laneWidth = 6'd32;
    endcase
  endfunction

  // One restoring step: shift in the dividend bit and trial-subtract.
  // Result is {new partial remainder, quotient bit}. The partial remainder
  // stays below the divisor, so the low W bits always hold it. With a zero
  // divisor it only ever holds the dividend bits seen so far, so it fits too.
  function automatic logic [8:0] laneStep8(input logic [7:0] r, input logic b,
                                           input logic [7:0] d);
    logic [8:0] shifted;
    shifted = {r, b};
    if (shifted >= {1'b0, d}) laneStep8 = {8'(shifted - {1'b0, d}), 1'b1};
    else                      laneStep8 = {shifted[7:0], 1'b0};
  endfunction

  function automatic logic [16:0] laneStep16(input logic [15:0] r, input logic b,
                                             input logic [15:0] d);
    logic [16:0] shifted;
    shifted = {r, b};
    if (shifted >= {1'b0, d}) laneStep16 = {16'(shifted - {1'b0, d}), 1'b1};
    else                      laneStep16 = {shifted[15:0], 1'b0};
  endfunction

  function automatic logic [32:0] laneStep32(input logic [31:0] r, input logic b,
                                             input logic [31:0] d);
    logic [32:0] shifted;
    shifted = {r, b};
    if (shifted >= {1'b0, d}) laneStep32 = {32'(shifted - {1'b0, d}), 1'b1};
    else                      laneStep32 = {shifted[31:0], 1'b0};
  endfunction

  // Per-lane iteration for the latched mode. Each lane shifts its own
  // dividend and quotient, so no bit ever crosses a lane boundary.
  always_comb begin
    stepRem = rem_q;
    stepQuo = quo_q;
    stepDvd = dvd_q;
    case (mode_q)
      MODE_4X8: begin
        for (int i = 0; i < 4; i++) begin
          {stepRem[i*8 +: 8], stepQuo[i*8]} =
            laneStep8(rem_q[i*8 +: 8], dvd_q[i*8+7], dvs_q[i*8 +: 8]);
          stepQuo[i*8+1 +: 7] = quo_q[i*8 +: 7];
          stepDvd[i*8 +: 8]   = {dvd_q[i*8 +: 7], 1'b0};
        end
      end
      MODE_2X16: begin
        for (int i = 0; i < 2; i++) begin
          {stepRem[i*16 +: 16], stepQuo[i*16]} =
            laneStep16(rem_q[i*16 +: 16], dvd_q[i*16+15], dvs_q[i*16 +: 16]);
          stepQuo[i*16+1 +: 15] = quo_q[i*16 +: 15];
          stepDvd[i*16 +: 16]   = {dvd_q[i*16 +: 15], 1'b0};
        end
      end
      MODE_1X32: begin
        {stepRem, stepQuo[0]} = laneStep32(rem_q, dvd_q[31], dvs_q);
        stepQuo[31:1] = quo_q[30:0];
        stepDvd       = {dvd_q[30:0], 1'b0};
      end
      default: begin
        stepRem = rem_q;
        stepQuo = quo_q;
        stepDvd = dvd_q;
      end
    endcase
  end

  // Zero-divisor detection per active lane. Lanes beyond the count stay 0.
  always_comb begin
    dzLanes = 4'b0000;
    case (mode_q)
      MODE_4X8:  for (int i = 0; i < 4; i++) dzLanes[i] = (dvs_q[i*8 +: 8] == 8'd0);
      MODE_2X16: for (int i = 0; i < 2; i++) dzLanes[i] = (dvs_q[i*16 +: 16] == 16'd0);
      MODE_1X32: dzLanes[0] = (dvs_q == '0);
      default:   dzLanes = 4'b0000;
    endcase
  end

  // Next-state and next-output logic. The DONE state commits the results into
  // the output registers, so the done pulse appears one clock after DONE.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    mode_d        = mode_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    dzFlags_d     = dzFlags_q;
    modeErr_d     = modeErr_q;
    resultValid_d = resultValid_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d        = mode;
          dvd_d         = dividend;
          dvs_d         = divisor;
          rem_d         = '0;
          quo_d         = '0;
          resultValid_d = 1'b0;
          dzFlags_d     = 4'b0000;
          modeErr_d     = 1'b0;
          if (mode == MODE_ILLEGAL) begin
            count_d = 6'd0;
            state_d = DONE;
          end else begin
            count_d = laneWidth(mode);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d   = stepRem;
        quo_d   = stepQuo;
        dvd_d   = stepDvd;
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) state_d = DONE;
      end
      DONE: begin
        done_d        = 1'b1;
        resultValid_d = 1'b1;
        state_d       = IDLE;
        if (mode_q == MODE_ILLEGAL) begin
          modeErr_d   = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          dzFlags_d   = 4'b0000;
        end else begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
          dzFlags_d   = dzLanes;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation immediately.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q       <= IDLE;
      count_q       <= 6'd0;
      mode_q        <= MODE_RESET;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      dzFlags_q     <= 4'b0000;
      modeErr_q     <= 1'b0;
      resultValid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      mode_q        <= mode_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      dzFlags_q     <= dzFlags_d;
      modeErr_q     <= modeErr_d;
      resultValid_q <= resultValid_d;
      done_q        <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign result_valid = resultValid_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign dz_flags     = dzFlags_q;
  assign mode_err     = modeErr_q;

endmodule

// File: tb/tb_simd_div_core.sv
// -----------------------------------------------------------------------------
// tb_simd_div_core
//   Self-checking bench for simd_div_core. It runs a directed sequence followed
//   by randomized operations. Results are compared against a lane-wise model
//   built from plain division and modulo.
// -----------------------------------------------------------------------------
module tb_simd_div_core;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic        resultValid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [3:0]  dzFlags;
  logic        modeErr;

  int assertCount = 0;
  int failCount = 0;

  simd_div_core #(.DATA_W(32), .MODE_RESET(2'b10)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rstN),
    .start          (start),
    .mode           (mode),
    .dividend       (dividend),
    .divisor        (divisor),
    .busy           (busy),
    .done           (done),
    .result_valid   (resultValid),
    .quotient       (quotient),
    .remainder      (remainder),
    .dz_flags       (dzFlags),
    .mode_err       (modeErr)
  );

  always #5 clk = ~clk;

  // One comparison. Each call counts as an evaluated assertion.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int laneBits(input logic [1:0] m);
    if (m == 2'b00)      return 8;
    else if (m == 2'b01) return 16;
    else                 return 32;
  endfunction

  // Lane-wise reference: quotient and remainder by plain arithmetic. A zero
  // divisor gives an all-ones quotient, the dividend as remainder, and a flag.
  function automatic void model(input logic [1:0] m, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic [3:0] dz);
    longint unsigned na, nb, mask, qAcc, rAcc;
    int w;
    q = 32'd0; r = 32'd0; dz = 4'b0000;
    if (m == 2'b11) return;
    w = laneBits(m);
    mask = (64'd1 << w) - 64'd1;
    qAcc = 0; rAcc = 0;
    for (int i = 0; i < 32 / w; i++) begin
      na = (longint'(a) >> (i * w)) & mask;
      nb = (longint'(b) >> (i * w)) & mask;
      if (nb == 0) begin
        qAcc |= mask << (i * w);
        rAcc |= na << (i * w);
        dz[i] = 1'b1;
      end else begin
        qAcc |= (na / nb) << (i * w);
        rAcc |= (na % nb) << (i * w);
      end
    end
    q = 32'(qAcc);
    r = 32'(rAcc);
  endfunction

  // Pulse start for one clock. Then scramble the operand inputs so that any
  // late sampling of them would corrupt the result.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mode = m; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Run one operation and check everything observable about it. If injectAt
  // is not negative, a second start carrying other operands is issued that
  // many clocks into the operation.
  task automatic runAndCheck(input string tag, input logic [1:0] m,
                             input logic [31:0] a, input logic [31:0] b,
                             input int injectAt);
    logic [31:0] expQ, expR;
    logic [3:0]  expDz;
    int          expLat, expBusy, lat, busyCyc;
    logic        clearedAtStart;
    model(m, a, b, expQ, expR, expDz);
    expLat  = (m == 2'b11) ? 1 : laneBits(m) + 1;
    expBusy = (m == 2'b11) ? 0 : laneBits(m);
    applyStimulus(m, a, b);
    clearedAtStart = ~resultValid & ~modeErr;
    lat = -1;
    busyCyc = 0;
    for (int n = 0; n < 100; n++) begin
      if (busy) busyCyc++;
      if (done) begin
        lat = n;
        break;
      end
      if (n == injectAt) begin
        start = 1'b1; mode = 2'b00; dividend = $urandom; divisor = $urandom;
      end else if (n == injectAt + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s.latency", tag), 64'(lat), 64'(expLat));
    checkOutput($sformatf("%s.busyCycles", tag), 64'(busyCyc), 64'(expBusy));
    checkOutput($sformatf("%s.clearAtStart", tag), 64'(clearedAtStart), 64'd1);
    checkOutput($sformatf("%s.quotient", tag), 64'(quotient), 64'(expQ));
    checkOutput($sformatf("%s.remainder", tag), 64'(remainder), 64'(expR));
    checkOutput($sformatf("%s.dzFlags", tag), 64'(dzFlags), 64'(expDz));
    checkOutput($sformatf("%s.modeErr", tag), 64'(modeErr), 64'(m == 2'b11));
    @(negedge clk);
    checkOutput($sformatf("%s.donePulse", tag), 64'({done, resultValid}), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, expQ, expR;
    logic [3:0]  expDz;
    logic [1:0]  m;
    int          doneSeen, busySeen;

    // Reset state
    #3;
    checkOutput("reset.flags", 64'({busy, done, resultValid, modeErr, dzFlags}), 64'd0);
    checkOutput("reset.data", {quotient, remainder}, 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Directed test vectors
    runAndCheck("plan4x8", 2'b00, 32'h64FF0710, 32'h0A100003, -1);
    checkOutput("plan4x8.constQ", 64'(quotient), 64'h0A0FFF05);
    checkOutput("plan4x8.constR", 64'(remainder), 64'h000F0701);
    checkOutput("plan4x8.constDz", 64'(dzFlags), 64'b0010);
    runAndCheck("plan2x16", 2'b01, 32'hABCD0001, 32'h00100001, -1);
    checkOutput("plan2x16.constQ", 64'(quotient), 64'h0ABC0001);
    checkOutput("plan2x16.constR", 64'(remainder), 64'h000D0000);
    runAndCheck("plan1x32", 2'b10, 32'hDEAD0011, 32'h00000100, -1);
    checkOutput("plan1x32.constQ", 64'(quotient), 64'h00DEAD00);
    checkOutput("plan1x32.constR", 64'(remainder), 64'h00000011);
    runAndCheck("dz2x16", 2'b01, 32'h1234BEEF, 32'h00000007, -1);
    runAndCheck("dz1x32", 2'b10, 32'h89ABCDEF, 32'h00000000, -1);

    // Illegal mode, followed by a legal start that clears mode_err
    runAndCheck("illegal", 2'b11, 32'h12345678, 32'h00000001, -1);
    runAndCheck("afterIllegal", 2'b00, 32'hFF80400A, 32'h03070005, -1);

    // A second start issued mid-operation is dropped and never queued
    runAndCheck("busyStart", 2'b10, 32'hFEDCBA98, 32'h00001234, 4);
    doneSeen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("busyStart.extraDone", 64'(doneSeen), 64'd0);
    model(2'b10, 32'hFEDCBA98, 32'h00001234, expQ, expR, expDz);
    checkOutput("busyStart.holdQ", 64'(quotient), 64'(expQ));

    // Asynchronous reset in the middle of a 2x16 operation
    applyStimulus(2'b01, 32'h12345678, 32'h00340007);
    repeat (9) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midReset.flags", 64'({busy, done, resultValid, modeErr, dzFlags}), 64'd0);
    checkOutput("midReset.data", {quotient, remainder}, 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    doneSeen = 0;
    busySeen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) doneSeen++;
      if (busy) busySeen++;
      @(negedge clk);
    end
    checkOutput("midReset.noDone", 64'(doneSeen), 64'd0);
    checkOutput("midReset.noBusy", 64'(busySeen), 64'd0);
    runAndCheck("afterReset", 2'b00, 32'hC8643219, 32'h0A050004, -1);

    // Randomized operations, with zero and small divisor lanes mixed in
    for (int t = 0; t < 24; t++) begin
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      b = $urandom;
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 3))
          0: b[j*8 +: 8] = 8'h00;
          1: b[j*8 +: 8] = 8'($urandom_range(1, 3));
          default: b[j*8 +: 8] = 8'($urandom);
        endcase
      end
      runAndCheck($sformatf("rand%0d", t), m, a, b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
